k_row_loader: RTL

- Producer side of the K-vector SRAM FIFO.
- Fetches a contiguous block of K rows from memory through a narrow request/response port, packs the beats of each row into one K_VECTOR_T, and pushes whole rows into the FIFO with the write_enable/sram_ready handshake.
- Sits between the memory controller and the KSRAM fill port; started once per attention tile.

---
 rtl/k_row_loader.sv | 114 +++++++++++
 1 files changed

// File: rtl/k_row_loader.sv
// k_row_loader: fetches a block of K rows beat-by-beat and pushes packed rows into the KSRAM FIFO.
// Define K_ROW_LOADER_PREFETCH_EN for ping-pong row buffers that overlap fetch with push.
module k_row_loader #(
    parameter int NUM_ROWS   = 16,
    parameter int ROW_BITS   = 512,
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [$clog2(NUM_ROWS):0] row_count,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    input  logic                      mem_resp_valid,
    input  logic [BUS_WIDTH-1:0]      mem_resp_data,
    output logic                      write_enable,
    input  logic                      sram_ready,
    output logic [ROW_BITS-1:0]       write_data
);
    localparam int BEATS = ROW_BITS / BUS_WIDTH;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int BI    = $clog2(BEATS);
    localparam int CW    = $clog2(NUM_ROWS) + 1;
    localparam logic [BW-1:0] NBEATS    = BW'(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] MAX_ROWS  = CW'(NUM_ROWS);
    localparam logic [ADDR_WIDTH-1:0] ROW_BYTES = ADDR_WIDTH'(ROW_BITS / 8);
    localparam logic [ADDR_WIDTH-1:0] BUS_BYTES = ADDR_WIDTH'(BUS_WIDTH / 8);
`ifdef K_ROW_LOADER_PREFETCH_EN
    localparam logic PF = 1'b1;
`else
    localparam logic PF = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, PUSH, FINISH} state_t;
    state_t state, state_n;

    logic [ADDR_WIDTH-1:0]          base;
    logic [CW-1:0]                  cnt, frow, prow, rc_sat;
    logic [BW-1:0]                  req_beat, resp_beat;
    logic [1:0]                     full, full_n;
    logic [BEATS-1:0][BUS_WIDTH-1:0] rbuf [2];
    logic active, fslot, pslot, pslot_n, fetch_en, req_fire, resp_fire, fill_done, xfer, last_xfer;

    // fetch side fills buffer frow, push side drains buffer prow; a buffer is reused only once drained
    always_comb begin
        active        = state == FETCH || state == PUSH;
        fslot         = PF & frow[0];
        pslot         = PF & prow[0];
        rc_sat        = row_count > MAX_ROWS ? MAX_ROWS : row_count;
        fetch_en      = active && frow < cnt && !full[fslot];
        mem_req_valid = fetch_en && req_beat < NBEATS;
        mem_req_addr  = base + ADDR_WIDTH'(frow) * ROW_BYTES + ADDR_WIDTH'(req_beat) * BUS_BYTES;
        req_fire      = mem_req_valid && mem_req_ready;
        resp_fire     = active && mem_resp_valid && resp_beat != req_beat;
        fill_done     = resp_fire && resp_beat == LAST_BEAT;
        write_enable  = state == PUSH;
        write_data    = rbuf[pslot];
        xfer          = write_enable && sram_ready;
        last_xfer     = xfer && prow == cnt - CW'(1);
        busy          = active;
        done          = state == FINISH;
        full_n        = full;
        if (fill_done) full_n[fslot] = 1'b1;
        if (xfer) full_n[pslot] = 1'b0;
        pslot_n       = PF & (prow[0] ^ xfer);
        state_n       = (state == IDLE)   ? (start ? (rc_sat == '0 ? FINISH : FETCH) : IDLE)
                      : (state == FINISH) ? IDLE
                      : last_xfer         ? FINISH
                      : full_n[pslot_n]   ? PUSH : FETCH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            base      <= '0;
            cnt       <= '0;
            frow      <= '0;
            prow      <= '0;
            req_beat  <= '0;
            resp_beat <= '0;
            full      <= '0;
            rbuf[0]   <= '0;
            rbuf[1]   <= '0;
        end else begin
            state <= state_n;
            full  <= full_n;
            if (state == IDLE && start) begin
                base      <= base_addr;
                cnt       <= rc_sat;
                frow      <= '0;
                prow      <= '0;
                req_beat  <= '0;
                resp_beat <= '0;
            end
            if (req_fire) req_beat <= req_beat + BW'(1);
            if (resp_fire) begin
                rbuf[fslot][resp_beat[BI-1:0]] <= mem_resp_data;
                resp_beat <= resp_beat + BW'(1);
            end
            if (fill_done) begin
                req_beat  <= '0;
                resp_beat <= '0;
                frow      <= frow + CW'(1);
            end
            if (xfer) prow <= prow + CW'(1);
        end
    end
endmodule
